md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the P7 five-stage MIPS pipeline.
- Executes mult/multu/div/divu over a fixed number of cycles, plus mthi/mtlo. Holds the HI/LO registers and exposes them for mfhi/mflo.
- Produces the `busy` stall request consumed by the hazard/stall unit, which freezes F/D and flushes E while `busy` is high.
- Cancels operations killed by an exception/interrupt flush.

---
 rtl/md_pkg.sv | 19 +
 rtl/md_calc.sv | 64 ++++++
 rtl/md_unit.sv | 85 ++++++++
 tb/tb_md_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operand width and
// the md_op encoding driven by the decoder.
package md_pkg;

  localparam int DATA_W  = 32;
  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE = 3'd0,
    MULT    = 3'd1,
    MULTU   = 3'd2,
    DIV     = 3'd3,
    DIVU    = 3'd4,
    MTHI    = 3'd5,
    MTLO    = 3'd6,
    MFHI    = 3'd7
  } md_op_e;

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply / divide producing the packed {hi,lo} result
// and a divide-by-zero flag for the sequencing logic in md_unit.
module md_calc
  import md_pkg::*;
(
  input  md_op_e                   op,
  input  logic [DATA_W-1:0]        a,
  input  logic [DATA_W-1:0]        b,
  output logic [2*DATA_W-1:0]      res,
  output logic                     div0
);

  logic                       b_zero;
  logic                       ovf;
  logic [DATA_W-1:0]          b_div_u;
  logic [DATA_W-1:0]          b_div_s;
  logic signed [DATA_W-1:0]   a_s;
  logic signed [DATA_W-1:0]   bd_s;
  logic signed [DATA_W-1:0]   q_s;
  logic signed [DATA_W-1:0]   r_s;
  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] b_x;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [DATA_W-1:0]          q_u;
  logic [DATA_W-1:0]          r_u;

  assign b_zero = (b == '0);
  // -2^31 / -1 overflows; dividing by 1 instead yields the wrapped quotient
  // and zero remainder without ever handing the divider an overflow case.
  assign ovf     = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
  assign b_div_u = b_zero ? DATA_W'(1) : b;
  assign b_div_s = (b_zero || ovf) ? DATA_W'(1) : b;

  assign a_s    = signed'(a);
  assign bd_s   = signed'(b_div_s);
  assign a_x    = a_s;
  assign b_x    = signed'(b);
  assign prod_s = a_x * b_x;
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign q_s    = a_s / bd_s;
  assign r_s    = a_s % bd_s;
  assign q_u    = a / b_div_u;
  assign r_u    = a % b_div_u;

  always_comb begin
    res  = '0;
    div0 = 1'b0;
    case (op)
      MULT:  res = prod_s;
      MULTU: res = prod_u;
      DIV: begin
        res  = {r_s, q_s};
        div0 = b_zero;
      end
      DIVU: begin
        res  = {r_u, q_u};
        div0 = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO; raises a stall request while
// an operation is in flight and a dependent MD instruction waits in D.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MD_OP_W-1:0]  md_op,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic                irq_flush,
  input  logic                md_in_d,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic                busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_op_e                op;
  logic                  is_mul;
  logic                  is_div;
  logic                  go_raw;
  logic                  go;
  logic                  mt_ok;
  logic [2*DATA_W-1:0]   calc_res;
  logic                  calc_div0;

  logic                  busy_r;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   res_p1;
  logic                  div0_p1;

  assign op     = md_op_e'(md_op);
  assign is_mul = (op == MULT) || (op == MULTU);
  assign is_div = (op == DIV) || (op == DIVU);
  assign go_raw = (is_mul || is_div) && !irq_flush;
  assign go     = go_raw && !busy_r;
  assign mt_ok  = !irq_flush && !busy_r;
  assign busy   = md_in_d && (go_raw || busy_r);

  md_calc u_calc (
    .op   (op),
    .a    (A),
    .b    (B),
    .res  (calc_res),
    .div0 (calc_div0)
  );

  // Start: latch result; busy phase: count down and commit on the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      busy_r  <= 1'b0;
      cnt     <= '0;
      res_p1  <= '0;
      div0_p1 <= 1'b0;
    end else if (go) begin
      res_p1  <= calc_res;
      div0_p1 <= calc_div0;
      cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      if (cnt == CNT_W'(1)) begin
        if (!div0_p1) begin
          hi <= res_p1[2*DATA_W-1:DATA_W];
          lo <= res_p1[DATA_W-1:0];
        end
        busy_r <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (mt_ok) begin
      if (op == MTHI) hi <= A;
      if (op == MTLO) lo <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed plan cases plus randomized
// mult/div traffic checked against a sign/magnitude arithmetic model.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        irq_flush;
  logic        md_in_d;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .A         (A),
    .B         (B),
    .irq_flush (irq_flush),
    .md_in_d   (md_in_d),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: work on magnitudes, then apply signs (quotient by sign
  // difference, remainder by dividend sign). Divide by zero keeps old HI/LO.
  function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
    logic        sgn;
    logic        na;
    logic        nb;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] p;
    sgn = (op == MULT) || (op == DIV);
    na  = sgn && a[31];
    nb  = sgn && b[31];
    ma  = na ? (~a + 32'd1) : a;
    mb  = nb ? (~b + 32'd1) : b;
    if (op == MULT || op == MULTU) begin
      p = {32'd0, ma} * {32'd0, mb};
      if (na ^ nb) p = ~p + 64'd1;
      return p;
    end
    if (b == 32'd0) return {h, l};
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = ~q + 32'd1;
    if (na) r = ~r + 32'd1;
    return {r, q};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mt_write(input logic [2:0] op, input logic [31:0] val);
    md_op = op; A = val; irq_flush = 1'b0;
    @(posedge clk); #1;
    md_op = MD_NONE;
    if (op == MTHI) m_hi = val;
    if (op == MTLO) m_lo = val;
  endtask

  // Issue one mult/div with md_in_d=1 and measure the busy window.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [63:0] exp;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
    int          cnt;
    bit          early;
    old_hi = m_hi;
    old_lo = m_lo;
    exp    = ref_calc(op, a, b, m_hi, m_lo);
    n      = (op == MULT || op == MULTU) ? 5 : 10;
    md_op = op; A = a; B = b; md_in_d = 1'b1; irq_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_busy got %b want 1", name, busy);
    end
    @(posedge clk); #1;
    md_op = MD_NONE; A = $urandom; B = $urandom;
    cnt = 0;
    early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
      if (hi !== old_hi || lo !== old_lo) early = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != n) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, cnt, n);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s early_hilo_write got 1 want 0", name);
    end
    checks++;
    if (hi !== exp[63:32] || lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h",
               name, hi, lo, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; md_op = MD_NONE; A = '0; B = '0; irq_flush = 1'b0; md_in_d = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
    end
    @(posedge clk); #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mt;
    mt_write(MTHI, 32'h0000_0011);
    mt_write(MTLO, 32'h0000_0022);
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL mt_write got hi=%h lo=%h want 11 22", hi, lo);
    end
  endtask

  task automatic test_plan;
    run_op(MULT,  32'hFFFF_FFFD, 32'd5, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_const got hi=%h lo=%h want ffffffff fffffff1", hi, lo);
    end
    run_op(MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
    checks++;
    if (hi !== 32'h0000_0004 || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL multu_const got hi=%h lo=%h want 00000004 fffffff1", hi, lo);
    end
    run_op(DIV,   32'hFFFF_FFF9, 32'd2, "div_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_const got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    run_op(DIVU,  32'd7, 32'd2, "divu");
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(DIV,   32'd17, 32'hFFFF_FFFB, "div_negdivisor");
    mt_write(MTHI, 32'h11);
    mt_write(MTLO, 32'h22);
    run_op(DIVU,  32'd9, 32'd0, "divu_zero");
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL divu_zero_keep got hi=%h lo=%h want 11 22", hi, lo);
    end
    run_op(DIV,   32'hFFFF_0000, 32'd0, "div_zero");
  endtask

  task automatic test_flush;
    md_op = MULT; A = 32'd3; B = 32'd4; irq_flush = 1'b1; md_in_d = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_busy got %b want 0", busy);
    end
    @(posedge clk); #1;
    md_op = MD_NONE; irq_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_busy got %b want 0", busy);
    end
    idle_cycles(7);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_mult_hilo got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
    md_op = MTLO; A = 32'h1234; irq_flush = 1'b1;
    @(posedge clk); #1;
    md_op = MD_NONE; irq_flush = 1'b0;
    checks++;
    if (lo !== m_lo) begin
      errors++;
      $display("FAIL flush_mtlo got lo=%h want %h", lo, m_lo);
    end
    // A flush arriving after the start edge must not cancel the operation.
    md_op = MULTU; A = 32'd1000; B = 32'd3000;
    @(posedge clk); #1;
    md_op = MD_NONE; irq_flush = 1'b1;
    @(posedge clk); #1;
    irq_flush = 1'b0;
    idle_cycles(4);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd3000000) begin
      errors++;
      $display("FAIL flush_inflight got hi=%h lo=%h want 0 %h", hi, lo, 32'd3000000);
    end
    m_hi = 32'd0;
    m_lo = 32'd3000000;
  endtask

  task automatic test_md_in_d_off_and_ignore;
    logic [63:0] exp;
    bit          seen;
    exp = ref_calc(MULT, 32'h8765_4321, 32'h0BAD_F00D, m_hi, m_lo);
    md_in_d = 1'b0; md_op = MULT; A = 32'h8765_4321; B = 32'h0BAD_F00D; irq_flush = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0) seen = 1'b1;
    @(posedge clk); #1;
    md_op = MTHI; A = 32'hDEAD_BEEF;
    @(negedge clk);
    if (busy !== 1'b0) seen = 1'b1;
    @(posedge clk); #1;
    md_op = DIV; A = 32'd50; B = 32'd3;
    @(negedge clk);
    if (busy !== 1'b0) seen = 1'b1;
    @(posedge clk); #1;
    md_op = MD_NONE;
    idle_cycles(2);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL busy_md_in_d0 got 1 want 0");
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL ignore_precommit got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
    idle_cycles(1);
    checks++;
    if (hi !== exp[63:32] || lo !== exp[31:0]) begin
      errors++;
      $display("FAIL ignore_commit got hi=%h lo=%h want hi=%h lo=%h",
               hi, lo, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    md_in_d = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL ignore_no_restart got busy_seen=%b hi=%h lo=%h want 0 hi=%h lo=%h",
               seen, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    for (int i = 0; i < 16; i++) begin
      op  = 3'($urandom_range(1, 4));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = 32'd0;
      else if (sel < 3)  b = 32'($urandom_range(1, 20));
      else if (sel == 3) b = -32'($urandom_range(1, 20));
      else               b = $urandom;
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  task automatic test_async_reset;
    bit seen;
    mt_write(MTHI, 32'hAAAA_0001);
    mt_write(MTLO, 32'h5555_0002);
    md_op = DIV; A = 32'd100; B = 32'd7; md_in_d = 1'b1;
    @(posedge clk); #1;
    md_op = MD_NONE;
    idle_cycles(2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL async_reset_no_commit got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_plan();
    test_flush();
    test_md_in_d_off_and_ignore();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
